// File: rtl/dmem_access_ctrl.sv
// Byte-serial data-memory sequencer for the MEM stage: splits a load/store into
// little-endian byte transfers on a ready/ack port and stalls the pipeline until done.
module dmem_access_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    input  logic                  req_write_i,
    input  logic [2:0]            size_i,
    input  logic                  extend_s_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [31:0]           rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [7:0]            mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [7:0]            mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [1:0]            last_q, last_d;
    logic                  write_q, write_d;
    logic                  ext_q, ext_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           buf_q, buf_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic                  done_q, done_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            cnt_inc;
    logic [1:0]            size_last;

    // last byte index of the access; unknown size codes fall back to a word
    always_comb begin
        case (size_i)
            3'b001:  size_last = 2'd0;
            3'b010:  size_last = 2'd1;
            default: size_last = 2'd3;
        endcase
    end

    assign cnt_inc = cnt_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        write_d     = write_q;
        ext_d       = ext_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        rdata_d     = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    write_d     = req_write_i;
                    last_d      = size_last;
                    ext_d       = extend_s_i;
                    addr_d      = addr_i;
                    wdata_d     = wdata_i;
                    cnt_d       = 2'd0;
                    buf_d       = 32'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = req_write_i;
                    mem_addr_d  = addr_i;
                    mem_wdata_d = wdata_i[7:0];
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_req_q && mem_ack_i) begin
                    if (!write_q) begin
                        buf_d[{cnt_q, 3'b000} +: 8] = mem_rdata_i;
                    end
                    if (cnt_q == last_q) begin
                        state_d   = S_DONE;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        done_d    = 1'b1;
                        if (!write_q) begin
                            case (last_q)
                                2'd0:    rdata_d = {{24{ext_q & buf_d[7]}}, buf_d[7:0]};
                                2'd1:    rdata_d = {{16{ext_q & buf_d[15]}}, buf_d[15:0]};
                                default: rdata_d = buf_d;
                            endcase
                        end
                    end else begin
                        cnt_d       = cnt_inc;
                        mem_addr_d  = addr_q + ADDR_WIDTH'(cnt_inc);
                        mem_wdata_d = wdata_q[{cnt_inc, 3'b000} +: 8];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            last_q      <= 2'd0;
            write_q     <= 1'b0;
            ext_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            done_q      <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            write_q     <= write_d;
            ext_q       <= ext_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
        end
    end

    assign stall_o     = (state_q == S_ACCESS) || ((state_q == S_IDLE) && req_valid_i);
    assign done_o      = done_q;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
